// File: rtl/cvxif_copro_pkg.sv
// Shared constants and types for the CV-X-IF custom-0 coprocessor responder.
// Optional MUL support is enabled by defining CVXIF_COPRO_MUL_EN.
package cvxif_copro_pkg;

  localparam logic [6:0] OPCODE_CUSTOM0 = 7'b0001011;
  localparam logic [2:0] F3_ADD         = 3'd0;
  localparam logic [2:0] F3_SUB         = 3'd1;
  localparam logic [2:0] F3_MUL         = 3'd2;
  localparam logic [2:0] F3_NOP         = 3'd4;

  typedef enum logic [1:0] {
    OP_ADD,
    OP_SUB,
    OP_NOP,
    OP_MUL
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
`ifdef CVXIF_COPRO_MUL_EN
    ST_RESP,
    ST_MUL2
`else
    ST_RESP
`endif
  } state_e;

  // Width-independent part of a buffered instruction; id and operands live beside it.
  typedef struct packed {
    op_e        op;
    logic [4:0] rd;
    logic       committed;
    logic       killed;
  } entry_ctl_t;

endpackage

// File: rtl/cvxif_copro_buffer.sv
// Circular pending-instruction buffer: tail push, head pop, occupancy count and
// parallel ID match that marks entries committed or killed.
module cvxif_copro_buffer
  import cvxif_copro_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int ID_W  = 3,
  parameter int DEPTH = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            push_i,
  input  logic [ID_W-1:0] push_id_i,
  input  entry_ctl_t      push_ctl_i,
  input  logic [XLEN-1:0] push_rs1_i,
  input  logic [XLEN-1:0] push_rs2_i,
  input  logic            pop_i,
  input  logic            commit_valid_i,
  input  logic [ID_W-1:0] commit_id_i,
  input  logic            commit_kill_i,
  output logic            head_valid_o,
  output logic [ID_W-1:0] head_id_o,
  output entry_ctl_t      head_ctl_o,
  output logic [XLEN-1:0] head_rs1_o,
  output logic [XLEN-1:0] head_rs2_o,
  output logic            full_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [DEPTH-1:0] vld_q;
  entry_ctl_t       ctl_q [DEPTH];
  logic [ID_W-1:0]  id_q  [DEPTH];
  logic [XLEN-1:0]  rs1_q [DEPTH];
  logic [XLEN-1:0]  rs2_q [DEPTH];

  logic       push_hit;
  entry_ctl_t push_ctl;

  // A commit landing in the same cycle as its push is folded into the new entry.
  always_comb begin
    push_hit           = commit_valid_i && (commit_id_i == push_id_i);
    push_ctl           = push_ctl_i;
    push_ctl.committed = push_hit && !commit_kill_i;
    push_ctl.killed    = push_hit && commit_kill_i;
  end

  // NOTE: registers use non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      vld_q    <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      for (int i = 0; i < DEPTH; i++) begin
        if (push_i && (wr_ptr_q == PTR_W'(i)))      vld_q[i] <= 1'b1;
        else if (pop_i && (rd_ptr_q == PTR_W'(i)))  vld_q[i] <= 1'b0;
      end
    end
  end

  // NOTE: payload storage is not reset; vld_q alone decides whether a slot means anything.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (push_i && (wr_ptr_q == PTR_W'(i))) begin
        ctl_q[i] <= push_ctl;
        id_q[i]  <= push_id_i;
        rs1_q[i] <= push_rs1_i;
        rs2_q[i] <= push_rs2_i;
      end else if (vld_q[i] && commit_valid_i && (id_q[i] == commit_id_i)) begin
        if (commit_kill_i) ctl_q[i].killed    <= 1'b1;
        else               ctl_q[i].committed <= 1'b1;
      end
    end
  end

  assign head_valid_o = vld_q[rd_ptr_q];
  assign head_id_o    = id_q[rd_ptr_q];
  assign head_ctl_o   = ctl_q[rd_ptr_q];
  assign head_rs1_o   = rs1_q[rd_ptr_q];
  assign head_rs2_o   = rs2_q[rd_ptr_q];
  assign full_o       = (count_q == CNT_W'(DEPTH));

endmodule

// File: rtl/cvxif_copro_responder.sv
// CV-X-IF coprocessor responder: custom-0 decode, in-order head FSM and result register.
// Define CVXIF_COPRO_MUL_EN to accept funct3=2 as a two-cycle MUL.
module cvxif_copro_responder
  import cvxif_copro_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int ID_W  = 3,
  parameter int DEPTH = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              issue_valid_i,
  output logic              issue_ready_o,
  input  logic [31:0]       issue_instr_i,
  input  logic [ID_W-1:0]   issue_id_i,
  input  logic [2*XLEN-1:0] issue_rs_i,
  input  logic [1:0]        issue_rs_valid_i,
  output logic              issue_accept_o,
  output logic              issue_writeback_o,
  input  logic              commit_valid_i,
  input  logic [ID_W-1:0]   commit_id_i,
  input  logic              commit_kill_i,
  output logic              result_valid_o,
  input  logic              result_ready_i,
  output logic [ID_W-1:0]   result_id_o,
  output logic [XLEN-1:0]   result_data_o,
  output logic [4:0]        result_rd_o,
  output logic              result_we_o
);

  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic       dec_ok, needs_rs, buf_full;
  op_e        dec_op;
  entry_ctl_t new_ctl, head_ctl;
  logic       head_valid, head_drop, head_go, pop, res_load;
  logic [ID_W-1:0] head_id;
  logic [XLEN-1:0] head_rs1, head_rs2, alu_res, res_value;
  state_e     state_q, state_d;
  logic       unused_instr;

  assign opcode       = issue_instr_i[6:0];
  assign funct3       = issue_instr_i[14:12];
  assign funct7       = issue_instr_i[31:25];
  assign unused_instr = ^issue_instr_i[24:15];

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    dec_ok = 1'b0;
    dec_op = OP_NOP;
    if (opcode == OPCODE_CUSTOM0 && funct7 == 7'd0) begin
      case (funct3)
        F3_ADD: begin dec_ok = 1'b1; dec_op = OP_ADD; end
        F3_SUB: begin dec_ok = 1'b1; dec_op = OP_SUB; end
        F3_NOP: begin dec_ok = 1'b1; dec_op = OP_NOP; end
`ifdef CVXIF_COPRO_MUL_EN
        F3_MUL: begin dec_ok = 1'b1; dec_op = OP_MUL; end
`endif
        default: ;
      endcase
    end
  end

  assign needs_rs          = dec_ok && (dec_op != OP_NOP);
  assign issue_ready_o     = !buf_full && (!needs_rs || (&issue_rs_valid_i));
  assign issue_accept_o    = issue_valid_i && issue_ready_o && dec_ok;
  assign issue_writeback_o = issue_accept_o && (dec_op != OP_NOP);

  always_comb begin
    new_ctl           = '0;
    new_ctl.op        = dec_op;
    new_ctl.rd        = issue_instr_i[11:7];
  end

  cvxif_copro_buffer #(.XLEN(XLEN), .ID_W(ID_W), .DEPTH(DEPTH)) u_buffer (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .push_i         (issue_accept_o),
    .push_id_i      (issue_id_i),
    .push_ctl_i     (new_ctl),
    .push_rs1_i     (issue_rs_i[XLEN-1:0]),
    .push_rs2_i     (issue_rs_i[2*XLEN-1:XLEN]),
    .pop_i          (pop),
    .commit_valid_i (commit_valid_i),
    .commit_id_i    (commit_id_i),
    .commit_kill_i  (commit_kill_i),
    .head_valid_o   (head_valid),
    .head_id_o      (head_id),
    .head_ctl_o     (head_ctl),
    .head_rs1_o     (head_rs1),
    .head_rs2_o     (head_rs2),
    .full_o         (buf_full)
  );

  assign head_drop = head_valid && (head_ctl.killed || head_ctl.op == OP_NOP);
  assign head_go   = head_valid && head_ctl.committed && !head_drop;

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (head_go) state_d = ST_EXEC;
`ifdef CVXIF_COPRO_MUL_EN
      ST_EXEC: state_d = (head_ctl.op == OP_MUL) ? ST_MUL2 : ST_RESP;
      ST_MUL2: state_d = ST_RESP;
`else
      ST_EXEC: state_d = ST_RESP;
`endif
      ST_RESP: if (result_ready_i) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef CVXIF_COPRO_MUL_EN
  logic            mul_load;
  logic [XLEN-1:0] mul_q;

  // The product is registered in EXEC; MUL2 then retires it like any other result.
  always_ff @(posedge clk_i) begin
    if (mul_load) mul_q <= head_rs1 * head_rs2;
  end
`endif

  always_comb begin
    pop      = 1'b0;
    res_load = 1'b0;
`ifdef CVXIF_COPRO_MUL_EN
    mul_load = 1'b0;
`endif
    case (state_q)
      ST_IDLE: pop = head_drop;
      ST_EXEC: begin
`ifdef CVXIF_COPRO_MUL_EN
        if (head_ctl.op == OP_MUL) begin
          mul_load = 1'b1;
        end else begin
          pop      = 1'b1;
          res_load = 1'b1;
        end
`else
        pop      = 1'b1;
        res_load = 1'b1;
`endif
      end
`ifdef CVXIF_COPRO_MUL_EN
      ST_MUL2: begin
        pop      = 1'b1;
        res_load = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  always_comb begin
    case (head_ctl.op)
      OP_ADD:  alu_res = head_rs1 + head_rs2;
      OP_SUB:  alu_res = head_rs1 - head_rs2;
      default: alu_res = '0;
    endcase
  end

`ifdef CVXIF_COPRO_MUL_EN
  assign res_value = (state_q == ST_MUL2) ? mul_q : alu_res;
`else
  assign res_value = alu_res;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      result_id_o   <= '0;
      result_data_o <= '0;
      result_rd_o   <= '0;
      result_we_o   <= 1'b0;
    end else if (res_load) begin
      result_id_o   <= head_id;
      result_data_o <= res_value;
      result_rd_o   <= head_ctl.rd;
      result_we_o   <= 1'b1;
    end
  end

  assign result_valid_o = (state_q == ST_RESP);

endmodule

// File: tb/tb_cvxif_copro_responder.sv
// Directed and randomized bench for cvxif_copro_responder against a queue-based reference model.
module tb_cvxif_copro_responder;

  localparam int XLEN  = 32;
  localparam int ID_W  = 3;
  localparam int DEPTH = 4;
  localparam logic [6:0] OPC = 7'b0001011;

  logic            clk, rst_i;
  logic            issue_valid_i, issue_ready_o, issue_accept_o, issue_writeback_o;
  logic [31:0]     issue_instr_i;
  logic [ID_W-1:0] issue_id_i;
  logic [XLEN-1:0] rs1_d, rs2_d;
  logic [1:0]      issue_rs_valid_i;
  logic            commit_valid_i, commit_kill_i;
  logic [ID_W-1:0] commit_id_i;
  logic            result_valid_o, result_ready_i, result_we_o;
  logic [ID_W-1:0] result_id_o;
  logic [XLEN-1:0] result_data_o;
  logic [4:0]      result_rd_o;

  cvxif_copro_responder #(.XLEN(XLEN), .ID_W(ID_W), .DEPTH(DEPTH)) dut (
    .clk_i             (clk),
    .rst_i             (rst_i),
    .issue_valid_i     (issue_valid_i),
    .issue_ready_o     (issue_ready_o),
    .issue_instr_i     (issue_instr_i),
    .issue_id_i        (issue_id_i),
    .issue_rs_i        ({rs2_d, rs1_d}),
    .issue_rs_valid_i  (issue_rs_valid_i),
    .issue_accept_o    (issue_accept_o),
    .issue_writeback_o (issue_writeback_o),
    .commit_valid_i    (commit_valid_i),
    .commit_id_i       (commit_id_i),
    .commit_kill_i     (commit_kill_i),
    .result_valid_o    (result_valid_o),
    .result_ready_i    (result_ready_i),
    .result_id_o       (result_id_o),
    .result_data_o     (result_data_o),
    .result_rd_o       (result_rd_o),
    .result_we_o       (result_we_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests;
  int n_fail;

  typedef struct {
    logic [ID_W-1:0] id;
    logic [4:0]      rd;
    int              op;   // 0 ADD, 1 SUB, 2 NOP, 3 MUL
    logic [31:0]     a;
    logic [31:0]     b;
    bit              committed;
    bit              killed;
  } mdl_t;

  mdl_t            mq[$];
  bit              stall_q;
  logic [ID_W-1:0] sv_id;
  logic [31:0]     sv_data;
  logic [4:0]      sv_rd;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk_instr(input logic [6:0] f7, input logic [2:0] f3,
                                           input logic [4:0] rd, input logic [6:0] opc);
    return {f7, 5'd2, 5'd1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] ref_result(input mdl_t e);
    logic [63:0] p;
    case (e.op)
      0:       return e.a + e.b;
      1:       return e.a - e.b;
      3: begin
        p = {32'd0, e.a} * {32'd0, e.b};
        return p[31:0];
      end
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [ID_W-1:0] free_id();
    for (int v = 0; v < (1 << ID_W); v++) begin
      bit used = 1'b0;
      foreach (mq[j]) if (mq[j].id == ID_W'(v)) used = 1'b1;
      if (!used) return ID_W'(v);
    end
    return '0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    issue_valid_i  = 1'b0;
    commit_valid_i = 1'b0;
    commit_kill_i  = 1'b0;
  endtask

  task automatic drive_issue(input logic [31:0] instr, input logic [ID_W-1:0] id,
                             input logic [31:0] a, input logic [31:0] b);
    issue_instr_i    = instr;
    issue_id_i       = id;
    rs1_d            = a;
    rs2_d            = b;
    issue_rs_valid_i = 2'b11;
    issue_valid_i    = 1'b1;
  endtask

  task automatic drive_commit(input logic [ID_W-1:0] id, input logic kill);
    commit_valid_i = 1'b1;
    commit_id_i    = id;
    commit_kill_i  = kill;
  endtask

  task automatic wait_valid(input int max, input string tag);
    int k = 0;
    while (!result_valid_o && k < max) begin
      tick();
      k++;
    end
    check(tag, result_valid_o, 1'b1);
  endtask

  task automatic watch_none(input int cycles, input string tag);
    bit seen = 1'b0;
    repeat (cycles) begin
      tick();
      if (result_valid_o) seen = 1'b1;
    end
    check(tag, seen, 1'b0);
  endtask

  task automatic rnd_cycle(input bit drain);
    int kind, op, cidx, npop;
    int cand[$];
    bit recog, ckill, exp_acc;
    logic [1:0] rsv;
    logic [4:0] rd;
    logic [6:0] f7;
    logic [2:0] f3;
    logic [ID_W-1:0] nid;
    mdl_t e;
    quiet();
    cidx = -1; op = 0; recog = 1'b0; rsv = 2'b11; rd = '0; nid = '0; npop = 0;
    if (!drain && mq.size() < DEPTH && $urandom_range(0, 1) == 1) begin
      kind = $urandom_range(0, 9);
      f7   = 7'd0;
      case (kind)
        0, 1, 2, 3: begin op = 0; f3 = 3'd0; end
        4, 5, 6:    begin op = 1; f3 = 3'd1; end
        7:          begin op = 2; f3 = 3'd4; end
        8:          begin op = 0; f3 = 3'd0; f7 = 7'd1; end
        default:    begin op = 3; f3 = 3'd2; end
      endcase
      recog = (kind <= 7);
`ifdef CVXIF_COPRO_MUL_EN
      if (kind == 9) recog = 1'b1;
`endif
      if ($urandom_range(0, 3) == 0) rsv = 2'($urandom_range(0, 2));
      rd  = 5'($urandom_range(1, 31));
      nid = free_id();
      drive_issue(mk_instr(f7, f3, rd, OPC), nid, $urandom, $urandom);
      issue_rs_valid_i = rsv;
    end
    foreach (mq[i]) if (!mq[i].committed && !mq[i].killed) cand.push_back(i);
    if (cand.size() > 0 && (drain || $urandom_range(0, 2) == 0)) begin
      cidx  = cand[$urandom_range(0, cand.size() - 1)];
      ckill = ($urandom_range(0, 3) == 0);
      drive_commit(mq[cidx].id, ckill);
    end
    result_ready_i = drain ? 1'b1 : 1'($urandom_range(0, 1));
    #1;
    exp_acc = 1'b0;
    if (issue_valid_i) begin
      if (recog && op != 2 && rsv != 2'b11) check("rnd_rs_gate", issue_ready_o, 1'b0);
      exp_acc = issue_ready_o && recog;
      check("rnd_accept", issue_accept_o, exp_acc);
      check("rnd_writeback", issue_writeback_o, exp_acc && op != 2);
    end
    if (stall_q) begin
      check("rnd_hold_valid", result_valid_o, 1'b1);
      check("rnd_hold_id", result_id_o, sv_id);
      check("rnd_hold_data", result_data_o, sv_data);
      check("rnd_hold_rd", result_rd_o, sv_rd);
    end
    if (result_valid_o) begin
      check("rnd_we", result_we_o, 1'b1);
      if (result_ready_i) begin
        while (mq.size() > 0 && (mq[0].killed || mq[0].op == 2)) begin
          void'(mq.pop_front());
          npop++;
        end
        if (mq.size() == 0) begin
          check("rnd_spurious_result", result_valid_o, 1'b0);
        end else begin
          e = mq.pop_front();
          npop++;
          check("rnd_in_order_committed", e.committed, 1'b1);
          check("rnd_id", result_id_o, e.id);
          check("rnd_rd", result_rd_o, e.rd);
          check("rnd_data", result_data_o, ref_result(e));
        end
      end
    end
    stall_q = result_valid_o && !result_ready_i;
    sv_id   = result_id_o;
    sv_data = result_data_o;
    sv_rd   = result_rd_o;
    if (cidx >= 0) begin
      cidx -= npop;
      if (cidx >= 0) begin
        if (ckill) mq[cidx].killed = 1'b1;
        else       mq[cidx].committed = 1'b1;
      end
    end
    if (exp_acc) begin
      e = '{id: nid, rd: rd, op: op, a: rs1_d, b: rs2_d, committed: 1'b0, killed: 1'b0};
      mq.push_back(e);
    end
    tick();
  endtask

  initial begin
    int left;
    n_tests = 0; n_fail = 0;
    stall_q = 1'b0; sv_id = '0; sv_data = '0; sv_rd = '0;
    rst_i = 1'b1;
    quiet();
    result_ready_i = 1'b0; issue_instr_i = '0; issue_id_i = '0;
    rs1_d = '0; rs2_d = '0; issue_rs_valid_i = 2'b00; commit_id_i = '0;
    repeat (2) tick();
    rst_i = 1'b0;
    #1;
    check("rst_valid", result_valid_o, 1'b0);
    check("rst_id", result_id_o, 0);
    check("rst_data", result_data_o, 0);
    check("rst_rd", result_rd_o, 0);
    check("rst_we", result_we_o, 1'b0);
    check("rst_ready", issue_ready_o, 1'b1);

    // ADD with wrap-around, committed in the issue cycle, then held with ready low.
    drive_issue(mk_instr(7'd0, 3'd0, 5'd7, OPC), 3'd2, 32'hFFFF_FFFF, 32'd2);
    drive_commit(3'd2, 1'b0);
    #1;
    check("add_ready", issue_ready_o, 1'b1);
    check("add_accept", issue_accept_o, 1'b1);
    check("add_writeback", issue_writeback_o, 1'b1);
    tick(); quiet();
    check("add_t0_idle", result_valid_o, 1'b0);
    tick();
    check("add_t1_idle", result_valid_o, 1'b0);
    tick();
    check("add_t2_valid", result_valid_o, 1'b1);
    check("add_data", result_data_o, 32'h1);
    check("add_id", result_id_o, 2);
    check("add_rd", result_rd_o, 7);
    check("add_we", result_we_o, 1'b1);
    repeat (2) begin
      tick();
      check("add_hold_valid", result_valid_o, 1'b1);
      check("add_hold_data", result_data_o, 32'h1);
    end
    result_ready_i = 1'b1;
    tick();
    result_ready_i = 1'b0;
    check("add_released", result_valid_o, 1'b0);

    // SUB committed late: no result until two cycles after the commit.
    drive_issue(mk_instr(7'd0, 3'd1, 5'd9, OPC), 3'd1, 32'd3, 32'd5);
    #1;
    check("sub_accept", issue_accept_o, 1'b1);
    tick(); quiet();
    repeat (3) begin
      check("sub_wait_commit", result_valid_o, 1'b0);
      tick();
    end
    drive_commit(3'd1, 1'b0);
    tick(); quiet();
    check("sub_c0", result_valid_o, 1'b0);
    tick();
    check("sub_c1", result_valid_o, 1'b0);
    tick();
    check("sub_c2_valid", result_valid_o, 1'b1);
    check("sub_data", result_data_o, 32'hFFFF_FFFE);
    check("sub_id", result_id_o, 1);
    result_ready_i = 1'b1;
    tick();
    result_ready_i = 1'b0;

    // Fill the buffer, check backpressure, then kill one and commit the rest.
    for (int k = 0; k < 4; k++) begin
      drive_issue(mk_instr(7'd0, 3'd0, 5'(10 + k), OPC), ID_W'(k), 32'(k * 100), 32'd7);
      #1;
      check("full_ready", issue_ready_o, 1'b1);
      tick();
    end
    drive_issue(mk_instr(7'd0, 3'd0, 5'd20, OPC), 3'd4, 32'd1, 32'd1);
    #1;
    check("full_ready_low", issue_ready_o, 1'b0);
    check("full_no_accept", issue_accept_o, 1'b0);
    quiet();
    drive_commit(3'd0, 1'b1);
    tick();
    for (int k = 1; k < 4; k++) begin
      drive_commit(ID_W'(k), 1'b0);
      tick();
    end
    quiet();
    result_ready_i = 1'b1;
    for (int k = 1; k < 4; k++) begin
      wait_valid(20, "full_wait_result");
      check("full_order_id", result_id_o, k);
      check("full_data", result_data_o, k * 100 + 7);
      check("full_rd", result_rd_o, 10 + k);
      tick();
    end
    watch_none(8, "full_no_extra");
    result_ready_i = 1'b0;

    // Rejected encodings, an unknown-ID commit, and a committed NOP.
    drive_issue(mk_instr(7'd1, 3'd0, 5'd3, OPC), 3'd6, 32'd1, 32'd1);
    #1;
    check("rej_f7_accept", issue_accept_o, 1'b0);
    check("rej_f7_ready", issue_ready_o, 1'b1);
    tick();
    drive_issue(mk_instr(7'd0, 3'd0, 5'd3, 7'h33), 3'd6, 32'd1, 32'd1);
    #1;
    check("rej_opc_accept", issue_accept_o, 1'b0);
    tick(); quiet();
    drive_commit(3'd6, 1'b0);
    tick(); quiet();
    drive_issue(mk_instr(7'd0, 3'd4, 5'd4, OPC), 3'd5, 32'd0, 32'd0);
    issue_rs_valid_i = 2'b00;
    drive_commit(3'd5, 1'b0);
    #1;
    check("nop_ready", issue_ready_o, 1'b1);
    check("nop_accept", issue_accept_o, 1'b1);
    check("nop_writeback", issue_writeback_o, 1'b0);
    tick(); quiet();
    result_ready_i = 1'b1;
    watch_none(8, "rej_nop_no_result");
    result_ready_i = 1'b0;

    // MUL: one cycle later than ADD when enabled, rejected otherwise.
    drive_issue(mk_instr(7'd0, 3'd2, 5'd12, OPC), 3'd3, 32'h0001_0001, 32'h0001_0001);
    drive_commit(3'd3, 1'b0);
    #1;
`ifdef CVXIF_COPRO_MUL_EN
    check("mul_accept", issue_accept_o, 1'b1);
    tick(); quiet();
    tick(); tick();
    check("mul_t2_idle", result_valid_o, 1'b0);
    tick();
    check("mul_t3_valid", result_valid_o, 1'b1);
    check("mul_data", result_data_o, 32'h0002_0001);
    result_ready_i = 1'b1;
    tick();
    result_ready_i = 1'b0;
`else
    check("mul_rejected", issue_accept_o, 1'b0);
    tick(); quiet();
    result_ready_i = 1'b1;
    watch_none(6, "mul_no_result");
    result_ready_i = 1'b0;
`endif

    // Reset while a result is held and two entries are still pending.
    for (int k = 0; k < 3; k++) begin
      drive_issue(mk_instr(7'd0, 3'd0, 5'd5, OPC), ID_W'(k), 32'(k), 32'd1);
      drive_commit(ID_W'(k), 1'b0);
      tick();
    end
    quiet();
    wait_valid(10, "rst_wait_resp");
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    check("rst_mid_valid", result_valid_o, 1'b0);
    check("rst_mid_id", result_id_o, 0);
    check("rst_mid_data", result_data_o, 0);
    check("rst_mid_we", result_we_o, 1'b0);
    result_ready_i = 1'b1;
    watch_none(12, "rst_no_stale");
    for (int k = 0; k < 4; k++) begin
      drive_issue(mk_instr(7'd0, 3'd0, 5'd6, OPC), ID_W'(k), 32'd0, 32'd0);
      #1;
      check("rst_buffer_empty", issue_ready_o, 1'b1);
      tick();
    end
    quiet();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;

    // Randomized traffic against the reference queue, then a full drain.
    repeat (600) rnd_cycle(1'b0);
    repeat (80)  rnd_cycle(1'b1);
    left = 0;
    foreach (mq[i]) if (!mq[i].killed && mq[i].op != 2) left++;
    check("drain_all_delivered", left, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
